// File: rtl/adc_cap_pkg.sv
// Shared constants for the ADC capture packer: default widths and FSM state encoding.
package adc_cap_pkg;

  localparam int SMP_W_DEF   = 14;
  localparam int PACK_N_DEF  = 4;
  localparam int LEN_W_DEF   = 16;
  localparam int FIFO_AW_DEF = 3;
  localparam int WORD_W_DEF  = SMP_W_DEF * PACK_N_DEF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/cap_word_fifo.sv
// Single-clock show-ahead FIFO for packed capture words; rd_data is the head entry whenever !empty.
module cap_word_fifo #(
  parameter int DW = 57,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          rd_go;
  logic          wr_go;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_go = rd_en && !empty;
  // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign wr_go = wr_en && (!full || rd_go);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_go) wr_ptr <= wr_ptr + 1'b1;
      if (rd_go) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/adc_cap_packer.sv
// Triggered ADC capture: packs PACK_N samples per word over cap_len words and queues them for the DMA side.
module adc_cap_packer
  import adc_cap_pkg::*;
#(
  parameter int SMP_W   = SMP_W_DEF,
  parameter int PACK_N  = PACK_N_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic                    clk125,
  input  logic                    rst,
  input  logic                    cap_arm,
  input  logic                    cap_trig,
  input  logic                    cap_abort,
  input  logic                    cap_mode,
  input  logic [LEN_W-1:0]        cap_len,
  input  logic [SMP_W-1:0]        smp_data,
  input  logic                    smp_vld,
  input  logic                    smp_of,
  output logic [SMP_W*PACK_N-1:0] m_data,
  output logic                    m_vld,
  input  logic                    m_rdy,
  output logic                    m_last,
  output logic                    cap_busy,
  output logic                    capr_rdy,
  output logic                    ovf_err,
  output logic                    of_flag
);

  localparam int WORD_W = SMP_W * PACK_N;
  localparam int IDX_W  = (PACK_N > 1) ? $clog2(PACK_N) : 1;

  logic [1:0]        state;
  logic [IDX_W-1:0]  pack_idx;
  logic [IDX_W-1:0]  base_idx;
  logic [WORD_W-1:0] pack_buf;
  logic [WORD_W-1:0] word_next;
  logic [WORD_W-1:0] word_reg;
  logic              word_pend;
  logic              pend_last;
  logic [LEN_W-1:0]  words_packed;
  logic [LEN_W-1:0]  len_lat;
  logic [LEN_W-1:0]  len_req;
  logic [LEN_W-1:0]  base_cnt;
  logic [LEN_W-1:0]  len_now;
  logic [LEN_W-1:0]  cnt_next;
  logic              cap_start;
  logic              cap_done;
  logic              smp_take;
  logic              word_full;
  logic              is_last;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [WORD_W:0]   fifo_dout;

  assign len_req   = (cap_len == '0) ? LEN_W'(1) : cap_len;
  assign cap_start = (state == ST_ARMED) && cap_trig && !cap_abort;
  assign cap_done  = (words_packed == len_lat);
  // The trigger-cycle sample opens word 0, so index and count restart from zero on that cycle.
  assign smp_take  = smp_vld && !cap_abort && (cap_start || ((state == ST_CAPT) && !cap_done));
  assign base_idx  = cap_start ? '0 : pack_idx;
  assign base_cnt  = cap_start ? '0 : words_packed;
  assign len_now   = cap_start ? len_req : len_lat;
  assign cnt_next  = base_cnt + LEN_W'(1);
  assign word_full = smp_take && (base_idx == IDX_W'(PACK_N - 1));
  assign is_last   = (cnt_next == len_now);

  always_comb begin
    word_next = cap_start ? '0 : pack_buf;
    for (int k = 0; k < PACK_N; k++) begin
      if (base_idx == IDX_W'(k)) word_next[k*SMP_W +: SMP_W] = smp_data;
    end
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      pack_idx     <= '0;
      words_packed <= '0;
      len_lat      <= '0;
      pack_buf     <= '0;
      word_reg     <= '0;
      word_pend    <= 1'b0;
      pend_last    <= 1'b0;
    end else if (cap_abort) begin
      pack_idx     <= '0;
      words_packed <= '0;
      word_pend    <= 1'b0;
      pend_last    <= 1'b0;
    end else begin
      word_pend <= word_full;
      if (cap_start) begin
        len_lat      <= len_req;
        pack_idx     <= '0;
        words_packed <= '0;
      end
      // Completed words are staged one cycle before the FIFO write; the counter advances even if dropped.
      if (word_full) begin
        word_reg     <= word_next;
        pend_last    <= is_last;
        pack_idx     <= '0;
        words_packed <= cnt_next;
      end else if (smp_take) begin
        pack_buf <= word_next;
        pack_idx <= base_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      state   <= ST_IDLE;
      ovf_err <= 1'b0;
      of_flag <= 1'b0;
    end else if (cap_abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cap_arm) begin
            state   <= ST_ARMED;
            ovf_err <= 1'b0;
            of_flag <= 1'b0;
          end
        end
        ST_ARMED: if (cap_trig) state <= ST_CAPT;
        ST_CAPT:  if (word_pend && pend_last) state <= ST_DRAIN;
        default:  if (fifo_empty) state <= cap_mode ? ST_ARMED : ST_IDLE;
      endcase
      if (word_pend && fifo_full && !fifo_rd) ovf_err <= 1'b1;
      if (smp_vld && smp_of && ((state == ST_CAPT) || cap_start)) of_flag <= 1'b1;
    end
  end

  cap_word_fifo #(
    .DW (WORD_W + 1),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk125),
    .rst     (rst),
    .flush   (cap_abort),
    .wr_en   (word_pend),
    .wr_data ({pend_last, word_reg}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_vld    = !fifo_empty;
  assign fifo_rd  = m_vld && m_rdy;
  assign m_data   = m_vld ? fifo_dout[WORD_W-1:0] : '0;
  assign m_last   = m_vld && fifo_dout[WORD_W];
  assign cap_busy = (state != ST_IDLE);
  assign capr_rdy = (state == ST_DRAIN) && fifo_empty && !cap_abort;

endmodule

// File: tb/tb_adc_cap_packer.sv
// Randomised and directed bench for adc_cap_packer against a word-queue reference model.
module tb_adc_cap_packer;

  localparam int SMP_W  = 14;
  localparam int PACK_N = 4;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 8;
  localparam int WORD_W = SMP_W * PACK_N;

  typedef enum int {M_IDLE, M_ARMED, M_CAPT, M_DRAIN} mstate_t;
  typedef struct {
    logic [WORD_W-1:0] data;
    logic              last;
  } word_t;

  logic              clk125 = 1'b0;
  logic              rst;
  logic              cap_arm, cap_trig, cap_abort, cap_mode;
  logic [LEN_W-1:0]  cap_len;
  logic [SMP_W-1:0]  smp_data;
  logic              smp_vld, smp_of;
  logic [WORD_W-1:0] m_data;
  logic              m_vld, m_rdy, m_last;
  logic              cap_busy, capr_rdy, ovf_err, of_flag;

  adc_cap_packer #(
    .SMP_W   (SMP_W),
    .PACK_N  (PACK_N),
    .LEN_W   (LEN_W),
    .FIFO_AW (3)
  ) dut (
    .clk125    (clk125),
    .rst       (rst),
    .cap_arm   (cap_arm),
    .cap_trig  (cap_trig),
    .cap_abort (cap_abort),
    .cap_mode  (cap_mode),
    .cap_len   (cap_len),
    .smp_data  (smp_data),
    .smp_vld   (smp_vld),
    .smp_of    (smp_of),
    .m_data    (m_data),
    .m_vld     (m_vld),
    .m_rdy     (m_rdy),
    .m_last    (m_last),
    .cap_busy  (cap_busy),
    .capr_rdy  (capr_rdy),
    .ovf_err   (ovf_err),
    .of_flag   (of_flag)
  );

  always #4 clk125 = ~clk125;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: capture state, partial word, staged word and FIFO contents as a queue.
  mstate_t          ms = M_IDLE;
  int               m_len = 1;
  int               m_words = 0;
  logic [SMP_W-1:0] part[$];
  word_t            mq[$];
  bit               m_pend = 0;
  word_t            m_pword;
  bit               m_ovf = 0;
  bit               m_of = 0;

  logic [WORD_W-1:0] rxq[$];
  int                rx_last_cnt = 0;
  int                capr_cnt = 0;
  logic              obs_vld;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep();
    mstate_t pre;
    bit      rd, was_empty, take, start;
    logic [WORD_W-1:0] w;
    pre = ms;
    if (cap_abort) begin
      mq.delete();
      part.delete();
      m_pend  = 0;
      m_words = 0;
      ms      = M_IDLE;
      return;
    end
    was_empty = (mq.size() == 0);
    rd        = !was_empty && m_rdy;
    if (rd) void'(mq.pop_front());
    if (m_pend) begin
      if (mq.size() < DEPTH) mq.push_back(m_pword);
      else m_ovf = 1;
    end
    take  = 0;
    start = 0;
    case (ms)
      M_IDLE: if (cap_arm) begin
        ms = M_ARMED; m_ovf = 0; m_of = 0;
      end
      M_ARMED: if (cap_trig) begin
        ms = M_CAPT; start = 1;
        m_len = (cap_len == 0) ? 1 : int'(cap_len);
        m_words = 0;
        part.delete();
        take = smp_vld;
      end
      M_CAPT: begin
        if (m_pend && m_pword.last) ms = M_DRAIN;
        take = smp_vld && (m_words < m_len);
      end
      M_DRAIN: if (was_empty) ms = cap_mode ? M_ARMED : M_IDLE;
    endcase
    if (smp_vld && smp_of && (start || pre == M_CAPT)) m_of = 1;
    m_pend = 0;
    if (take) begin
      part.push_back(smp_data);
      if (part.size() == PACK_N) begin
        w = '0;
        for (int k = 0; k < PACK_N; k++) w |= WORD_W'(part[k]) << (k * SMP_W);
        m_words++;
        m_pword.data = w;
        m_pword.last = (m_words == m_len);
        m_pend = 1;
        part.delete();
      end
    end
  endtask

  task automatic tick();
    logic [WORD_W-1:0] exp_data;
    logic              exp_vld, exp_last, exp_capr;
    @(negedge clk125);
    exp_vld  = (mq.size() != 0);
    exp_data = exp_vld ? mq[0].data : '0;
    exp_last = exp_vld ? mq[0].last : 1'b0;
    exp_capr = (ms == M_DRAIN) && !exp_vld && !cap_abort;
    checkOutput("m_vld", 64'(m_vld), 64'(exp_vld));
    checkOutput("m_data", 64'(m_data), 64'(exp_data));
    checkOutput("m_last", 64'(m_last), 64'(exp_last));
    checkOutput("cap_busy", 64'(cap_busy), 64'(ms != M_IDLE));
    checkOutput("capr_rdy", 64'(capr_rdy), 64'(exp_capr));
    checkOutput("ovf_err", 64'(ovf_err), 64'(m_ovf));
    checkOutput("of_flag", 64'(of_flag), 64'(m_of));
    obs_vld = m_vld;
    if (m_vld && m_rdy) begin
      rxq.push_back(m_data);
      if (m_last) rx_last_cnt++;
    end
    if (capr_rdy) capr_cnt++;
    modelStep();
    @(posedge clk125);
    #1;
  endtask

  task automatic applyStimulus(input logic arm, input logic trig, input logic abort, input logic vld,
                               input logic [SMP_W-1:0] data, input logic of, input logic rdy);
    cap_arm   = arm;
    cap_trig  = trig;
    cap_abort = abort;
    smp_vld   = vld;
    smp_data  = data;
    smp_of    = of;
    m_rdy     = rdy;
    tick();
  endtask

  task automatic clearRx();
    rxq.delete();
    rx_last_cnt = 0;
    capr_cnt    = 0;
  endtask

  task automatic drainIdle(input string tag, input int budget);
    int n = 0;
    while (cap_busy && n < budget) begin
      applyStimulus(0, 0, 0, 0, '0, 0, 1);
      n++;
    end
    checkOutput(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic waitCapr(input string tag, input int target, input int budget);
    int n = 0;
    while (capr_cnt < target && n < budget) begin
      applyStimulus(0, 0, 0, 0, '0, 0, 1);
      n++;
    end
    checkOutput(tag, 64'(n < budget), 64'd1);
  endtask

  logic [WORD_W-1:0] exp_w0, exp_w2;

  initial begin
    rst = 1'b1;
    cap_arm = 0; cap_trig = 0; cap_abort = 0; cap_mode = 0; cap_len = '0;
    smp_data = '0; smp_vld = 0; smp_of = 0; m_rdy = 0;
    repeat (3) @(posedge clk125);
    #1 rst = 1'b0;

    checkOutput("rst_m_vld", 64'(m_vld), 64'd0);
    checkOutput("rst_m_data", 64'(m_data), 64'd0);
    checkOutput("rst_busy", 64'(cap_busy), 64'd0);
    checkOutput("rst_flags", 64'({m_last, capr_rdy, ovf_err, of_flag}), 64'd0);

    // Basic capture: 3 words of counting samples, plus exact first-m_vld latency.
    clearRx();
    cap_mode = 0; cap_len = 16'd3;
    applyStimulus(1, 0, 0, 0, '0, 0, 1);
    applyStimulus(0, 1, 0, 1, 14'd1, 0, 1);
    for (int s = 2; s <= 12; s++) begin
      applyStimulus(0, 0, 0, 1, SMP_W'(s), 0, 1);
      if (s == 5) checkOutput("vld_t_plus1", 64'(obs_vld), 64'd0);
      if (s == 6) checkOutput("vld_t_plus2", 64'(obs_vld), 64'd1);
    end
    drainIdle("basic_drain_timeout", 30);
    exp_w0 = (WORD_W'(4) << 42) | (WORD_W'(3) << 28) | (WORD_W'(2) << 14) | WORD_W'(1);
    exp_w2 = (WORD_W'(12) << 42) | (WORD_W'(11) << 28) | (WORD_W'(10) << 14) | WORD_W'(9);
    checkOutput("basic_words", 64'(rxq.size()), 64'd3);
    if (rxq.size() == 3) begin
      checkOutput("basic_w0", 64'(rxq[0]), 64'(exp_w0));
      checkOutput("basic_w2", 64'(rxq[2]), 64'(exp_w2));
    end
    checkOutput("basic_last", 64'(rx_last_cnt), 64'd1);
    checkOutput("basic_capr", 64'(capr_cnt), 64'd1);

    // Overflow: consumer stalled, 12 words into an 8-deep FIFO.
    clearRx();
    cap_len = 16'd12;
    applyStimulus(1, 0, 0, 0, '0, 0, 0);
    applyStimulus(0, 1, 0, 1, 14'd100, 0, 0);
    for (int s = 1; s < 48; s++) applyStimulus(0, 0, 0, 1, SMP_W'(100 + s), 0, 0);
    repeat (4) applyStimulus(0, 0, 0, 0, '0, 0, 0);
    checkOutput("ovf_set", 64'(ovf_err), 64'd1);
    checkOutput("ovf_busy", 64'(cap_busy), 64'd1);
    drainIdle("ovf_drain_timeout", 40);
    checkOutput("ovf_words", 64'(rxq.size()), 64'd8);
    checkOutput("ovf_no_last", 64'(rx_last_cnt), 64'd0);
    checkOutput("ovf_capr", 64'(capr_cnt), 64'd1);

    // Auto re-arm: two captures, busy stays high between them.
    clearRx();
    cap_mode = 1; cap_len = 16'd1;
    applyStimulus(1, 0, 0, 0, '0, 0, 1);
    applyStimulus(0, 1, 0, 1, 14'd7, 0, 1);
    for (int s = 0; s < 3; s++) applyStimulus(0, 0, 0, 1, SMP_W'(s), 0, 1);
    waitCapr("rearm1_timeout", 1, 20);
    checkOutput("rearm_busy", 64'(cap_busy), 64'd1);
    applyStimulus(0, 1, 0, 1, 14'd8, 0, 1);
    for (int s = 0; s < 3; s++) applyStimulus(0, 0, 0, 1, SMP_W'(s + 20), 0, 1);
    waitCapr("rearm2_timeout", 2, 20);
    checkOutput("rearm_words", 64'(rxq.size()), 64'd2);
    checkOutput("rearm_lasts", 64'(rx_last_cnt), 64'd2);
    cap_mode = 0;
    applyStimulus(0, 0, 1, 0, '0, 0, 1);
    checkOutput("rearm_abort_idle", 64'(cap_busy), 64'd0);

    // Abort mid-capture with three words queued.
    clearRx();
    cap_len = 16'd8;
    applyStimulus(1, 0, 0, 0, '0, 0, 0);
    applyStimulus(0, 1, 0, 1, 14'd1, 0, 0);
    for (int s = 1; s < 12; s++) applyStimulus(0, 0, 0, 1, SMP_W'(s), 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, '0, 0, 0);
    checkOutput("abort_pre_vld", 64'(m_vld), 64'd1);
    applyStimulus(0, 0, 1, 1, 14'd5, 0, 0);
    applyStimulus(0, 0, 0, 1, 14'd6, 0, 1);
    checkOutput("abort_vld", 64'(obs_vld), 64'd0);
    repeat (5) applyStimulus(0, 0, 0, 0, '0, 0, 1);
    checkOutput("abort_busy", 64'(cap_busy), 64'd0);
    checkOutput("abort_no_capr", 64'(capr_cnt), 64'd0);

    // Zero length, ignored trig/arm, over-range flag.
    clearRx();
    cap_len = 16'd0;
    applyStimulus(0, 1, 0, 1, 14'd3, 0, 1);
    checkOutput("trig_idle_ignored", 64'(cap_busy), 64'd0);
    applyStimulus(1, 0, 0, 0, '0, 0, 1);
    applyStimulus(0, 1, 0, 1, 14'h3fff, 0, 1);
    applyStimulus(1, 0, 0, 1, 14'd2, 0, 1);
    applyStimulus(0, 0, 0, 1, 14'd3, 1, 1);
    applyStimulus(0, 0, 0, 1, 14'd4, 0, 1);
    drainIdle("len0_drain_timeout", 20);
    checkOutput("len0_words", 64'(rxq.size()), 64'd1);
    checkOutput("len0_last", 64'(rx_last_cnt), 64'd1);
    checkOutput("len0_of_flag", 64'(of_flag), 64'd1);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      cap_len  = LEN_W'($urandom_range(0, 5));
      cap_mode = ($urandom_range(0, 3) == 0);
      applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                    SMP_W'($urandom), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 4) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
